// File: rtl/terminal_writer.sv
// ----------------------------------------------------------------------------
// terminal_writer
// Turns a host byte stream into characters in a text-mode video RAM with a
// cursor, carriage return / line feed / backspace / form feed handling and
// hardware scrolling through a circular row pointer (top_row).
//
// Ports
//   clk         in   1  rising-edge clock for all logic
//   reset_high  in   1  asynchronous, active-high reset
//   in_valid    in   1  in_byte offered this cycle
//   in_ready    out  1  block accepts in_byte this cycle (only while idle)
//   in_byte     in   8  character or control byte
//   vram_valid  in   1  display read strobe
//   vram_row    in   5  physical row of the display read
//   vram_col    in   7  column of the display read
//   vram_byte   out  8  registered read data, one cycle after vram_valid
//   top_row     out  5  physical row shown at the top of the screen
//   cursor_row  out  5  physical row of the cursor
//   cursor_col  out  7  column of the cursor
// ----------------------------------------------------------------------------
module terminal_writer #(
  parameter int unsigned COLS  = 100,
  parameter int unsigned ROWS  = 30,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic       clk,
  input  logic       reset_high,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_byte,
  input  logic       vram_valid,
  input  logic [4:0] vram_row,
  input  logic [6:0] vram_col,
  output logic [7:0] vram_byte,
  output logic [4:0] top_row,
  output logic [4:0] cursor_row,
  output logic [6:0] cursor_col
);

  localparam logic [6:0] LAST_COL = 7'(COLS - 1);
  localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    ST_CLEAR_ALL = 2'd0,
    ST_IDLE      = 2'd1,
    ST_CLEAR_ROW = 2'd2
  } state_t;

  // Next physical row, wrapping ROWS-1 back to 0.
  function automatic logic [4:0] row_inc(input logic [4:0] r);
    if (r == LAST_ROW) begin
      return 5'd0;
    end else begin
      return r + 5'd1;
    end
  endfunction

  // Physical row just above r on the circular screen; applied to top_row
  // it yields the bottom visible row.
  function automatic logic [4:0] row_prev(input logic [4:0] r);
    if (r == 5'd0) begin
      return LAST_ROW;
    end else begin
      return r - 5'd1;
    end
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return ((b >= 8'h20) && (b <= 8'h7E)) || (b >= 8'h80);
  endfunction

  state_t      state_q, state_d;
  logic        ready_q, ready_d;
  logic [4:0]  top_q, top_d;
  logic [4:0]  crow_q, crow_d;
  logic [6:0]  ccol_q, ccol_d;
  logic [4:0]  clr_row_q, clr_row_d;
  logic [6:0]  clr_col_q, clr_col_d;
  logic [7:0]  vram_byte_q;

  logic        accept_s;
  logic        newline_s;
  logic        we_s;
  logic [11:0] waddr_s;
  logic [7:0]  wdata_s;

  // Character storage, addressed {row, col}; deliberately has no reset.
  logic [7:0]  ram_q [0:4095];

  assign accept_s   = in_valid && ready_q;
  assign in_ready   = ready_q;
  assign top_row    = top_q;
  assign cursor_row = crow_q;
  assign cursor_col = ccol_q;
  assign vram_byte  = vram_byte_q;

  // Next-state, cursor and RAM write-port logic.
  always_comb begin
    state_d   = state_q;
    top_d     = top_q;
    crow_d    = crow_q;
    ccol_d    = ccol_q;
    clr_row_d = clr_row_q;
    clr_col_d = clr_col_q;
    we_s      = 1'b0;
    waddr_s   = {crow_q, ccol_q};
    wdata_s   = BLANK;
    newline_s = 1'b0;

    case (state_q)
      ST_CLEAR_ALL: begin
        we_s    = 1'b1;
        waddr_s = {clr_row_q, clr_col_q};
        if (clr_col_q == LAST_COL) begin
          clr_col_d = 7'd0;
          if (clr_row_q == LAST_ROW) begin
            clr_row_d = 5'd0;
            state_d   = ST_IDLE;
          end else begin
            clr_row_d = clr_row_q + 5'd1;
          end
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      // After a scroll the cursor already sits on the row being recycled.
      ST_CLEAR_ROW: begin
        we_s    = 1'b1;
        waddr_s = {crow_q, clr_col_q};
        if (clr_col_q == LAST_COL) begin
          clr_col_d = 7'd0;
          state_d   = ST_IDLE;
        end else begin
          clr_col_d = clr_col_q + 7'd1;
        end
      end

      ST_IDLE: begin
        if (accept_s) begin
          if (is_printable(in_byte)) begin
            we_s    = 1'b1;
            wdata_s = in_byte;
            if (ccol_q == LAST_COL) begin
              ccol_d    = 7'd0;
              newline_s = 1'b1;
            end else begin
              ccol_d = ccol_q + 7'd1;
            end
          end else begin
            case (in_byte)
              8'h0D: ccol_d = 7'd0;
              8'h0A: newline_s = 1'b1;
              8'h08: begin
                if (ccol_q != 7'd0) begin
                  ccol_d = ccol_q - 7'd1;
                end else begin
                  ccol_d = ccol_q;
                end
              end
              8'h0C: begin
                state_d   = ST_CLEAR_ALL;
                top_d     = 5'd0;
                crow_d    = 5'd0;
                ccol_d    = 7'd0;
                clr_row_d = 5'd0;
                clr_col_d = 7'd0;
              end
              default: ccol_d = ccol_q;
            endcase
          end

          if (newline_s) begin
            if (crow_q != row_prev(top_q)) begin
              crow_d = row_inc(crow_q);
            end else begin
              // Scroll: the old top row becomes the new bottom row.
              crow_d    = top_q;
              top_d     = row_inc(top_q);
              clr_col_d = 7'd0;
              state_d   = ST_CLEAR_ROW;
            end
          end else begin
            top_d = top_d;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d   = ST_CLEAR_ALL;
        clr_row_d = 5'd0;
        clr_col_d = 7'd0;
      end
    endcase

    ready_d = (state_d == ST_IDLE);
  end

  // Control and cursor registers.
  always_ff @(posedge clk or posedge reset_high) begin
    if (reset_high) begin
      state_q   <= ST_CLEAR_ALL;
      ready_q   <= 1'b0;
      top_q     <= 5'd0;
      crow_q    <= 5'd0;
      ccol_q    <= 7'd0;
      clr_row_q <= 5'd0;
      clr_col_q <= 7'd0;
    end else begin
      state_q   <= state_d;
      ready_q   <= ready_d;
      top_q     <= top_d;
      crow_q    <= crow_d;
      ccol_q    <= ccol_d;
      clr_row_q <= clr_row_d;
      clr_col_q <= clr_col_d;
    end
  end

  // RAM write port.
  always_ff @(posedge clk) begin
    if (we_s) begin
      ram_q[waddr_s] <= wdata_s;
    end
  end

  // Display read port; a same-cycle write to the same address returns old data.
  always_ff @(posedge clk or posedge reset_high) begin
    if (reset_high) begin
      vram_byte_q <= 8'h00;
    end else if (vram_valid) begin
      vram_byte_q <= ram_q[{vram_row, vram_col}];
    end
  end

endmodule
